// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
// Optional feature macro: ID_EX_BUBBLE_COUNT_EN enables a saturating 32-bit hazard-bubble counter.
module id_ex_pipe_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int AOPW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_pc_plus4,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm_ext,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_uses_rt,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_dst,
  input  logic            id_branch,
  input  logic [AOPW-1:0] id_alu_op,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_pc_plus4,
  output logic [DW-1:0]   ex_rs_data,
  output logic [DW-1:0]   ex_rt_data,
  output logic [DW-1:0]   ex_imm_ext,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_dst,
  output logic            ex_branch,
  output logic [AOPW-1:0] ex_alu_op,
  output logic [31:0]     bubble_count
);

  typedef struct packed {
    logic            valid;
    logic [DW-1:0]   pc_plus4;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic [DW-1:0]   imm_ext;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            reg_dst;
    logic            branch;
    logic [AOPW-1:0] alu_op;
  } stage_t;

  localparam int SW = $bits(stage_t);

  stage_t stage_r;
  stage_t stage_next_s;
  stage_t load_s;
  logic   rt_match_s;
  logic   hazard_stall_s;

  // Load-use detection: the load in EX writes a register the ID instruction reads
  always_comb begin
    rt_match_s     = id_uses_rt & (stage_r.rt == id_rt);
    hazard_stall_s = id_valid & stage_r.valid & stage_r.mem_read
                   & (stage_r.rt != {RW{1'b0}})
                   & ((stage_r.rt == id_rs) | rt_match_s)
                   & ~flush;
  end

  // Normal load image; an invalid slot keeps its data but cannot write state
  always_comb begin
    load_s            = {SW{1'b0}};
    load_s.valid      = id_valid;
    load_s.pc_plus4   = id_pc_plus4;
    load_s.rs_data    = id_rs_data;
    load_s.rt_data    = id_rt_data;
    load_s.imm_ext    = id_imm_ext;
    load_s.rs         = id_rs;
    load_s.rt         = id_rt;
    load_s.rd         = id_rd;
    load_s.reg_write  = id_valid & id_reg_write;
    load_s.mem_to_reg = id_valid & id_mem_to_reg;
    load_s.mem_read   = id_valid & id_mem_read;
    load_s.mem_write  = id_valid & id_mem_write;
    load_s.alu_src    = id_valid & id_alu_src;
    load_s.reg_dst    = id_valid & id_reg_dst;
    load_s.branch     = id_valid & id_branch;
    load_s.alu_op     = {AOPW{id_valid}} & id_alu_op;
  end

  // Next-state priority: flush bubble, hold, hazard bubble, load
  always_comb begin
    stage_next_s = stage_r;
    if (flush) begin
      stage_next_s = {SW{1'b0}};
    end else if (hold) begin
      stage_next_s = stage_r;
    end else if (hazard_stall_s) begin
      stage_next_s = {SW{1'b0}};
    end else begin
      stage_next_s = load_s;
    end
  end

  // Stage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_r <= {SW{1'b0}};
    end else begin
      stage_r <= stage_next_s;
    end
  end

  assign hazard_stall  = hazard_stall_s;
  assign ex_valid      = stage_r.valid;
  assign ex_pc_plus4   = stage_r.pc_plus4;
  assign ex_rs_data    = stage_r.rs_data;
  assign ex_rt_data    = stage_r.rt_data;
  assign ex_imm_ext    = stage_r.imm_ext;
  assign ex_rs         = stage_r.rs;
  assign ex_rt         = stage_r.rt;
  assign ex_rd         = stage_r.rd;
  assign ex_reg_write  = stage_r.reg_write;
  assign ex_mem_to_reg = stage_r.mem_to_reg;
  assign ex_mem_read   = stage_r.mem_read;
  assign ex_mem_write  = stage_r.mem_write;
  assign ex_alu_src    = stage_r.alu_src;
  assign ex_reg_dst    = stage_r.reg_dst;
  assign ex_branch     = stage_r.branch;
  assign ex_alu_op     = stage_r.alu_op;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count_r;
  logic        count_bubble_s;

  // Only hazard bubbles count; flush is already excluded from hazard_stall_s
  assign count_bubble_s = hazard_stall_s & ~hold;

  // Saturating hazard-bubble counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count_r <= 32'h0000_0000;
    end else if (count_bubble_s && (bubble_count_r != 32'hFFFF_FFFF)) begin
      bubble_count_r <= bubble_count_r + 32'h0000_0001;
    end else begin
      bubble_count_r <= bubble_count_r;
    end
  end

  assign bubble_count = bubble_count_r;
`else
  assign bubble_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: a reference model pushes the expected EX state into a
// scoreboard queue each cycle; it is popped and compared after the clock edge.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hold, flush, id_valid, id_uses_rt;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch;
  logic [3:0]  id_alu_op;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_branch;
  logic [3:0]  ex_alu_op;
  logic [31:0] bubble_count;

  id_ex_pipe_reg #(.DW(32), .RW(5), .AOPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, m2r, mr, mw, asrc, rdst, br;
    logic [3:0]  aop;
    logic [31:0] bc;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  logic m_known = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t bubble_of(input exp_t e);
    exp_t r;
    r = e;
    r.valid = 1'b0; r.pc = 32'd0; r.rsd = 32'd0; r.rtd = 32'd0; r.imm = 32'd0;
    r.rs = 5'd0; r.rt = 5'd0; r.rd = 5'd0;
    r.rw = 1'b0; r.m2r = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.asrc = 1'b0; r.rdst = 1'b0; r.br = 1'b0;
    r.aop = 4'd0;
    return r;
  endfunction

  function automatic logic model_hazard();
    if (flush || !id_valid || !m.valid || !m.mr || m.rt == 5'd0) return 1'b0;
    if (m.rt == id_rs) return 1'b1;
    return id_uses_rt && (m.rt == id_rt);
  endfunction

  task automatic compare_all(input exp_t e);
    check_eq("ex_valid",      32'(ex_valid),      32'(e.valid));
    check_eq("ex_pc_plus4",   ex_pc_plus4,        e.pc);
    check_eq("ex_rs_data",    ex_rs_data,         e.rsd);
    check_eq("ex_rt_data",    ex_rt_data,         e.rtd);
    check_eq("ex_imm_ext",    ex_imm_ext,         e.imm);
    check_eq("ex_rs",         32'(ex_rs),         32'(e.rs));
    check_eq("ex_rt",         32'(ex_rt),         32'(e.rt));
    check_eq("ex_rd",         32'(ex_rd),         32'(e.rd));
    check_eq("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
    check_eq("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
    check_eq("ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
    check_eq("ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
    check_eq("ex_alu_src",    32'(ex_alu_src),    32'(e.asrc));
    check_eq("ex_reg_dst",    32'(ex_reg_dst),    32'(e.rdst));
    check_eq("ex_branch",     32'(ex_branch),     32'(e.br));
    check_eq("ex_alu_op",     32'(ex_alu_op),     32'(e.aop));
    check_eq("bubble_count",  bubble_count,       e.bc);
  endtask

  // One clock: check hazard_stall mid-cycle, push expected next state, compare after the edge.
  task automatic cycle();
    exp_t nx;
    exp_t got_e;
    logic hz;
    @(negedge clk);
    hz = model_hazard();
    if (m_known) check_eq("hazard_stall", 32'(hazard_stall), 32'(hz));
    nx = m;
    if (!rst_n) begin
      nx = bubble_of(m);
      nx.bc = 32'd0;
    end else if (flush) begin
      nx = bubble_of(m);
    end else if (hold) begin
      nx = m;
    end else if (hz) begin
      nx = bubble_of(m);
`ifdef ID_EX_BUBBLE_COUNT_EN
      if (nx.bc != 32'hFFFF_FFFF) nx.bc = nx.bc + 32'd1;
`endif
    end else begin
      nx.valid = id_valid; nx.pc = id_pc_plus4; nx.rsd = id_rs_data; nx.rtd = id_rt_data;
      nx.imm = id_imm_ext; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.rw = id_valid & id_reg_write;   nx.m2r = id_valid & id_mem_to_reg;
      nx.mr = id_valid & id_mem_read;    nx.mw = id_valid & id_mem_write;
      nx.asrc = id_valid & id_alu_src;   nx.rdst = id_valid & id_reg_dst;
      nx.br = id_valid & id_branch;      nx.aop = id_valid ? id_alu_op : 4'd0;
    end
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    compare_all(got_e);
    m = got_e;
    m_known = 1'b1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic mr, input logic ur);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_mem_read = mr; id_uses_rt = ur;
    id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
    id_reg_write = 1'b1; id_mem_to_reg = mr; id_mem_write = 1'b0;
    id_alu_src = 1'($urandom_range(0, 1)); id_reg_dst = 1'($urandom_range(0, 1));
    id_branch = 1'($urandom_range(0, 1)); id_alu_op = 4'($urandom_range(0, 15));
  endtask

  logic [31:0] snap_pc, snap_bc, saved_rtd;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every ID input driven high
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_uses_rt = 1'b1;
    id_pc_plus4 = 32'hFFFF_FFFF; id_rs_data = 32'hFFFF_FFFF; id_rt_data = 32'hFFFF_FFFF; id_imm_ext = 32'hFFFF_FFFF;
    id_rs = 5'h1F; id_rt = 5'h1F; id_rd = 5'h1F;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
    id_alu_src = 1'b1; id_reg_dst = 1'b1; id_branch = 1'b1; id_alu_op = 4'hF;
    m = '{valid: 1'b0, pc: 32'd0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
          rw: 1'b0, m2r: 1'b0, mr: 1'b0, mw: 1'b0, asrc: 1'b0, rdst: 1'b0, br: 1'b0, aop: 4'd0, bc: 32'd0};
    cycle();
    cycle();
    check_eq("rst_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_pc", ex_pc_plus4, 32'd0);
    check_eq("rst_stall", 32'(hazard_stall), 32'd0);
    check_eq("rst_bc", bubble_count, 32'd0);
    rst_n = 1'b1;

    // Pass-through
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    id_rt_data = 32'h1234_5678; id_imm_ext = 32'hFFFF_FFF0; id_alu_src = 1'b1;
    cycle();
    check_eq("pt_rt_data", ex_rt_data, 32'h1234_5678);
    check_eq("pt_imm", ex_imm_ext, 32'hFFFF_FFF0);
    check_eq("pt_alu_src", 32'(ex_alu_src), 32'd1);
    check_eq("pt_valid", 32'(ex_valid), 32'd1);

    // Load-use: lw $8 then add using $8
    set_instr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1);
    #1 check_eq("lu_stall", 32'(hazard_stall), 32'd1);
    cycle();
    check_eq("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check_eq("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    cycle();
    check_eq("lu_add_rs", 32'(ex_rs), 32'd8);
    check_eq("lu_add_valid", 32'(ex_valid), 32'd1);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check_eq("lu_bc", bubble_count, 32'd1);
`else
    check_eq("lu_bc", bubble_count, 32'd0);
`endif

    // $0 never stalls
    set_instr(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    #1 check_eq("r0_stall", 32'(hazard_stall), 32'd0);
    cycle();
    check_eq("r0_rd", 32'(ex_rd), 32'd4);

    // Flush beats a pending hazard
    set_instr(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0);
    cycle();
    snap_bc = bubble_count;
    set_instr(1'b1, 5'd9, 5'd1, 5'd5, 1'b0, 1'b1);
    flush = 1'b1;
    #1 check_eq("fl_stall", 32'(hazard_stall), 32'd0);
    cycle();
    flush = 1'b0;
    check_eq("fl_valid", 32'(ex_valid), 32'd0);
    check_eq("fl_bc", bubble_count, snap_bc);
    cycle();

    // Hold without hazard, then capture on release
    set_instr(1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1);
    cycle();
    snap_pc = ex_pc_plus4;
    hold = 1'b1;
    repeat (3) begin
      set_instr(1'b1, 5'd7, 5'd8, 5'd9, 1'b0, 1'b1);
      cycle();
      check_eq("hold_pc", ex_pc_plus4, snap_pc);
    end
    hold = 1'b0;
    id_pc_plus4 = 32'hCAFE_0000;
    cycle();
    check_eq("release_pc", ex_pc_plus4, 32'hCAFE_0000);

    // Hold while a hazard is pending
    set_instr(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 5'd7, 5'd2, 5'd3, 1'b0, 1'b1);
    hold = 1'b1;
    repeat (2) begin
      #1 check_eq("hold_hz_stall", 32'(hazard_stall), 32'd1);
      cycle();
    end
    hold = 1'b0;
    cycle();
    check_eq("hold_hz_bubble", 32'(ex_valid), 32'd0);
    cycle();
    check_eq("hold_hz_load", 32'(ex_rs), 32'd7);

    // Back-to-back dependent loads, dependency via rt
    set_instr(1'b1, 5'd1, 5'd11, 5'd0, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 5'd2, 5'd11, 5'd12, 1'b1, 1'b1);
    id_rt = 5'd11;
    cycle();
    cycle();
    id_rt = 5'd12;
    set_instr(1'b1, 5'd12, 5'd3, 5'd13, 1'b0, 1'b1);
    cycle();
    cycle();
    check_eq("b2b_rs", 32'(ex_rs), 32'd12);
    check_eq("b2b_valid", 32'(ex_valid), 32'd1);

    // Invalid slot: data loads, controls forced low
    set_instr(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
    saved_rtd = id_rt_data;
    cycle();
    check_eq("inv_rw", 32'(ex_reg_write), 32'd0);
    check_eq("inv_mr", 32'(ex_mem_read), 32'd0);
    check_eq("inv_rtd", ex_rt_data, saved_rtd);

    // Random traffic with a small register pool to provoke hazards
    for (int i = 0; i < 300; i++) begin
      set_instr(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      id_mem_write = 1'($urandom_range(0, 1));
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    hold = 1'b0; flush = 1'b0; rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
